// File: rtl/wb_burst_bram.sv
// rtl/wb_burst_bram.sv - Wishbone slave over block RAM with classic and registered-feedback burst cycles
// Optional macro WB_BURST_BRAM_ERR_EN: out-of-range addresses and linear wrap past the top raise wb_err_o.
module wb_burst_bram #(
    parameter int WWIDTH  = 32,
    parameter int ADDRESS = 25,
    parameter int DEPTH   = 10
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    input  logic [ADDRESS-1:0]    wb_adr_i,
    input  logic [WWIDTH/8-1:0]   wb_sel_i,
    input  logic [WWIDTH-1:0]     wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_rty_o,
    output logic                  wb_err_o,
    output logic [WWIDTH/8-1:0]   wb_sel_o,
    output logic [WWIDTH-1:0]     wb_dat_o
);
    localparam int NSEL = WWIDTH / 8;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

    state_t            state;
    logic [DEPTH-1:0]  addr_q;
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  next_addr;
    logic [DEPTH-1:0]  rd_addr;
    logic [WWIDTH-1:0] ram [2**DEPTH];
    logic [WWIDTH-1:0] rd_q;
    logic              xfer;
    logic              range_err;
    logic              wrap_err;

    assign xfer = wb_cyc_i & wb_stb_i & wb_ack_o;
    assign inc  = addr_q + 1'b1;

`ifdef WB_BURST_BRAM_ERR_EN
    assign range_err = |wb_adr_i[ADDRESS-1:DEPTH];
    assign wrap_err  = (wb_bte_i == 2'd0) && (&addr_q);
`else
    logic unused_upper;
    assign unused_upper = |wb_adr_i[ADDRESS-1:DEPTH];
    assign range_err    = 1'b0;
    assign wrap_err     = 1'b0;
`endif

    always_comb begin
        next_addr = addr_q;
        if (xfer) begin
            case (wb_bte_i)
                2'd1:    next_addr = {addr_q[DEPTH-1:2], inc[1:0]};
                2'd2:    next_addr = {addr_q[DEPTH-1:3], inc[2:0]};
                2'd3:    next_addr = {addr_q[DEPTH-1:4], inc[3:0]};
                default: next_addr = inc;
            endcase
        end
    end

    // Prefetch the beat after the current transfer so read data lines up with the registered ack
    assign rd_addr = (state == IDLE) ? wb_adr_i[DEPTH-1:0] : next_addr;

    always_ff @(posedge wb_clk_i) begin
        if (xfer && wb_we_i && !wb_rst_i) begin
            for (int k = 0; k < NSEL; k++) begin
                if (wb_sel_i[k]) begin
                    ram[addr_q][8*k +: 8] <= wb_dat_i[8*k +: 8];
                end
            end
        end
        rd_q <= ram[rd_addr];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else if (!wb_cyc_i) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_stb_i) begin
                        addr_q <= wb_adr_i[DEPTH-1:0];
                        if (range_err) begin
                            wb_err_o <= 1'b1;
                            state    <= SINGLE;
                        end else begin
                            wb_ack_o <= 1'b1;
                            state    <= (wb_cti_i == 3'd2) ? BURST : SINGLE;
                        end
                    end
                end
                SINGLE: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end
                BURST: begin
                    if (!wb_stb_i) begin
                        wb_ack_o <= 1'b0;
                    end else if (!wb_ack_o) begin
                        wb_ack_o <= 1'b1;
                    end else begin
                        addr_q <= next_addr;
                        if (wb_cti_i != 3'd2) begin
                            wb_ack_o <= 1'b0;
                            state    <= IDLE;
                        end else if (wrap_err) begin
                            // SINGLE clears the error beat and returns to IDLE
                            wb_ack_o <= 1'b0;
                            wb_err_o <= 1'b1;
                            state    <= SINGLE;
                        end
                    end
                end
                default: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign wb_rty_o = 1'b0;
    assign wb_dat_o = wb_ack_o ? rd_q : '0;
    assign wb_sel_o = (wb_ack_o && !wb_we_i) ? '1 : '0;

endmodule

// File: doc/wb_burst_bram.md
Name: wb_burst_bram

Overview:
- Single-clock 32-bit Wishbone slave backed by on-chip block RAM.
- Serves as the memory-side target of the DMA engine's b-port.
- Accepts classic single-word cycles and registered-feedback incrementing/wrapping bursts (cti=2) at one word per clock.
- Provides byte-lane writes and a registered acknowledge compatible with the DMA's burst master.

Parameters:
- WWIDTH, 32: data width (fixed 32; byte selects are WWIDTH/8 = 4).
- ADDRESS, 25: word-address width of wb_adr_i.
- DEPTH, 10: log2 of RAM depth in words (1024 words).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_cti_i  in  3  cycle type: 0/1 classic, 2 incrementing burst, 7 end-of-burst
- wb_bte_i  in  2  burst type: 0 linear, 1 wrap4, 2 wrap8, 3 wrap16
- wb_adr_i  in  ADDRESS  word address
- wb_sel_i  in  4  byte-lane write enables
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  acknowledge
- wb_rty_o  out  1  retry, tied 0
- wb_err_o  out  1  error (see Optional Feature)
- wb_sel_o  out  4  read byte lanes, 4'hF during read ack, else 0
- wb_dat_o  out  32  read data, valid while wb_ack_o=1, forced 0 otherwise

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_sel_o=0, wb_dat_o=0, state=IDLE, addr_q=0. RAM contents are not cleared.
- A transfer occurs on any edge where wb_cyc_i & wb_stb_i & wb_ack_o are all 1.
- Writes:
  - Commit at a transfer edge, to RAM[addr_q[DEPTH-1:0]].
  - Byte lane k is written only if wb_sel_i[k]=1.
- RAM read port:
  - Synchronous read.
  - Read address is wb_adr_i in IDLE, otherwise next_addr.
  - As a result, wb_dat_o is valid in the same cycle wb_ack_o is asserted.
- next_addr:
  - If a transfer is occurring, addr_q+1 with wrap per bte (wrap4: only bits[1:0] increment; wrap8: bits[2:0]; wrap16: bits[3:0]; linear: full DEPTH bits, wrapping at 2**DEPTH).
  - Otherwise addr_q.
- FSM states: IDLE, SINGLE, BURST.
- IDLE:
  - Leaves IDLE when cyc&stb: addr_q<=wb_adr_i and wb_ack_o<=1 on the next edge (latency 1).
  - If cti==2, go to BURST; otherwise go to SINGLE.
- SINGLE:
  - The ack lasts exactly 1 cycle; next edge wb_ack_o<=0 and return to IDLE.
  - Back-to-back classic cycles therefore take 2 clocks per word.
- BURST:
  - wb_ack_o is held at 1 while cyc&stb; addr_q<=next_addr each transfer.
  - If stb=0 (master wait state): no transfer, addr_q holds, wb_ack_o<=0. It re-asserts one cycle after stb returns.
  - A transfer with cti==7 (or cti!=2): wb_ack_o<=0, return to IDLE.
  - wb_cyc_i=0 in any state: wb_ack_o<=0, return to IDLE next edge, no further writes.
- wb_adr_i is ignored during BURST; addr_q is authoritative.
- A change of wb_bte_i mid-burst takes effect at the next increment.
- Reset mid-burst: no write on the reset edge; all outputs return to reset values next edge.
- Address range: if wb_adr_i[ADDRESS-1:DEPTH]!=0, the upper bits are ignored (aliasing), unless the Optional Feature is compiled in.

Optional Feature:
- Macro: WB_BURST_BRAM_ERR_EN.
- Defined:
  - An IDLE-state access with nonzero upper address bits asserts wb_err_o for 1 cycle instead of wb_ack_o, at latency 1.
  - No RAM write; wb_dat_o=0; FSM returns to IDLE (a burst is refused at its first beat).
  - A linear burst whose addr_q would wrap past 2**DEPTH-1 gets wb_err_o instead of ack on that beat, then returns to IDLE.
- Undefined: wb_err_o tied 0; out-of-range addresses alias and linear bursts wrap at 2**DEPTH.

Test Plan:
- Reset then classic write: adr=0x010, dat=0xDEADBEEF, sel=4'hF, cti=0 -> ack 1 cycle after stb, ack low next cycle. A classic read of 0x010 returns 0xDEADBEEF with ack, sel_o=4'hF.
- Byte lanes: write 0x11223344 sel=4'b0101 over 0xDEADBEEF at 0x010 -> read 0xDE22BE44.
- Linear burst write: adr=0x3FE, 4 beats cti=2,2,2,7, bte=0, data 1..4 -> ack high 4 consecutive cycles, then low. Reads give 0x3FE=1, 0x3FF=2, 0x000=3, 0x001=4 (ERR_EN undefined); with ERR_EN, the third beat gets err and the burst ends.
- Wrap4 burst read from adr=0x102 (RAM[0x100..0x103]=A,B,C,D), 4 beats bte=1 -> dat_o sequence C,D,A,B, one per clock.
- Master wait state: burst write where stb drops for 2 cycles after beat 2 -> ack drops, addr_q holds. Beat 3 lands at base+2; no extra or duplicate writes.
- Reset pulse during beat 3 of an 8-beat burst -> ack/err 0 next edge, beat-3 data not written, a subsequent classic read works normally. With ERR_EN, adr=0x0400000 -> err 1 cycle, no ack.
